// File: rtl/snake_dir_scheduler.sv
// Snake input controller: button sync/debounce, direction command queue and game-tick timebase.
// Optional feature macro: SNAKE_SPEEDUP_EN (speed_up shortens the tick period; otherwise the period is fixed).
module snake_dir_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int TICK_DIV        = 12_500_000,
  parameter int MIN_DIV         = 3_125_000,
  parameter int SPEED_STEP      = 625_000,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn,
  input  logic       enable,
  input  logic       clear,
  input  logic       speed_up,
  output logic       tick_o,
  output logic [1:0] dir_o,
  output logic       overflow_o
);

  localparam int MAX_CNT = (TICK_DIV > DEBOUNCE_CYCLES) ? TICK_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int QW      = $clog2(QUEUE_DEPTH + 1);
  localparam int IW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0] Q_ONE = {{(QW-1){1'b0}}, 1'b1};

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_lvl;
  logic [3:0]    r_lvl_d;
  logic [CW-1:0] r_db_cnt [4];
  logic [CW-1:0] r_tick_cnt;
  logic [1:0]    r_q [QUEUE_DEPTH];
  logic [QW-1:0] r_q_cnt;
  logic          r_tick;
  logic [1:0]    r_dir;
  logic          r_ovf;

  logic [CW-1:0] w_period;
  logic [3:0]    w_rise;
  logic          w_press_vld;
  logic [1:0]    w_press_dir;
  logic [1:0]    w_ref;
  logic          w_wrap;
  logic          w_pop;
  logic          w_push_req;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [IW-1:0] w_widx;

  // Two-flop synchroniser, then a level that only moves after a full run of disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_lvl   <= 4'b0000;
      r_lvl_d <= 4'b0000;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= {CW{1'b0}};
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= {CW{1'b0}};
        end else if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl[i]    <= r_sync2[i];
          r_db_cnt[i] <= {CW{1'b0}};
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + C_ONE;
        end
      end
    end
  end

  assign w_rise = r_lvl & ~r_lvl_d;

  // Button index doubles as the direction code (3=up, 2=down, 1=left, 0=right); highest wins.
  always_comb begin
    w_press_vld = 1'b0;
    w_press_dir = 2'b00;
    if (w_rise[3]) begin
      w_press_vld = 1'b1;
      w_press_dir = 2'b11;
    end else if (w_rise[2]) begin
      w_press_vld = 1'b1;
      w_press_dir = 2'b10;
    end else if (w_rise[1]) begin
      w_press_vld = 1'b1;
      w_press_dir = 2'b01;
    end else if (w_rise[0]) begin
      w_press_vld = 1'b1;
      w_press_dir = 2'b00;
    end else begin
      w_press_vld = 1'b0;
      w_press_dir = 2'b00;
    end
  end

  // Legality is judged against the last direction that will be in effect (queue tail or current).
  always_comb begin
    w_ref = r_dir;
    if (r_q_cnt != {QW{1'b0}}) begin
      w_ref = r_q[IW'(r_q_cnt - Q_ONE)];
    end else begin
      w_ref = r_dir;
    end
  end

  assign w_wrap     = enable && !clear && (r_tick_cnt == (w_period - C_ONE));
  assign w_pop      = w_wrap && (r_q_cnt != {QW{1'b0}});
  assign w_push_req = enable && !clear && w_press_vld && (w_press_dir[1] != w_ref[1]);
  assign w_full     = (r_q_cnt == QW'(QUEUE_DEPTH));
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_widx     = w_pop ? IW'(r_q_cnt - Q_ONE) : IW'(r_q_cnt);

  // Tick counter, shift-register command queue and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= {CW{1'b0}};
      r_q_cnt    <= {QW{1'b0}};
      r_tick     <= 1'b0;
      r_dir      <= 2'b00;
      r_ovf      <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= 2'b00;
    end else if (clear) begin
      r_tick_cnt <= {CW{1'b0}};
      r_q_cnt    <= {QW{1'b0}};
      r_tick     <= 1'b0;
      r_dir      <= 2'b00;
      r_ovf      <= 1'b0;
    end else if (!enable) begin
      r_tick_cnt <= {CW{1'b0}};
      r_tick     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_tick     <= w_wrap;
      r_ovf      <= w_drop;
      r_tick_cnt <= w_wrap ? {CW{1'b0}} : (r_tick_cnt + C_ONE);
      if (w_pop) begin
        r_dir <= r_q[0];
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) r_q[i] <= r_q[i+1];
      end
      if (w_push) r_q[w_widx] <= w_press_dir;
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + Q_ONE;
        2'b01:   r_q_cnt <= r_q_cnt - Q_ONE;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_period_pend;
  logic [CW-1:0] w_pend_next;

  // Saturating period reduction; compared before subtracting so it can never wrap.
  always_comb begin
    w_pend_next = r_period_pend;
    if (speed_up) begin
      w_pend_next = (r_period_pend >= CW'(MIN_DIV + SPEED_STEP)) ?
                    (r_period_pend - CW'(SPEED_STEP)) : CW'(MIN_DIV);
    end else begin
      w_pend_next = r_period_pend;
    end
  end

  // Pending period collects speed-ups; the active one only changes at a counter wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period      <= CW'(TICK_DIV);
      r_period_pend <= CW'(TICK_DIV);
    end else if (clear) begin
      r_period      <= CW'(TICK_DIV);
      r_period_pend <= CW'(TICK_DIV);
    end else begin
      r_period_pend <= w_pend_next;
      if (w_wrap) r_period <= w_pend_next;
    end
  end

  assign w_period = r_period;
`else
  logic w_unused_speed_up;
  assign w_unused_speed_up = speed_up;
  assign w_period          = CW'(TICK_DIV);
`endif

  assign tick_o     = r_tick;
  assign dir_o      = r_dir;
  assign overflow_o = r_ovf;

endmodule
